// File: rtl/linebuf_pkg.sv
// Shared declarations for the UART line buffer: FSM state encoding and default terminator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package linebuf_pkg;

  // Controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_RCV      = 3'd0,
    ST_WRITE    = 3'd1,
    ST_READ     = 3'd2,
    ST_TX_WAIT  = 3'd3,
    ST_TX_START = 3'd4,
    ST_TX_HOLD  = 3'd5
  } state_t;

  // Carriage return ends a line early when terminator mode is built in.
  localparam logic [7:0] TERM_DEFAULT = 8'h0D;

endpackage

// File: rtl/genram.sv
// Single-port synchronous RAM used as the line store; write-first is not needed, reads return old data.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; accepts a write or read every cycle.
//
// Ports: clk; we (write enable); addr (AW bits); din/dout (DW bits).
// INITFILE names the preload image handed to the implementation flow's memory-init step;
// contents are never touched by reset.
module genram #(
  parameter int    AW       = 4,
  parameter int    DW       = 8,
  parameter string INITFILE = "linebufini.list"
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/uart_line_buffer.sv
// Line buffer between uart_rx and uart_tx: stores bytes until a line completes, then replays it.
// Latency: byte write 1 cycle after rx_valid; first tx_start 3 cycles after the completing write.
// Backpressure: none upstream (bytes arriving outside RCV are dropped and flagged); waits on tx_ready.
//
// Ports: clk, rstn (sync, active-low); rx_data/rx_valid from the receiver; tx_ready from the
// transmitter; tx_data/tx_start to the transmitter; busy (replaying), level (bytes in line),
// dropped (sticky discard flag).
// Build option: define LINEBUF_TERM_EN to let the byte TERM end a line before LEN bytes.
module uart_line_buffer
  import linebuf_pkg::*;
#(
  parameter int            AW       = 4,
  parameter int            DW       = 8,
  parameter int            LEN      = 5,
  parameter logic [DW-1:0] TERM     = DW'(TERM_DEFAULT),
  parameter string         INITFILE = "linebufini.list"
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  input  logic          tx_ready,
  output logic [DW-1:0] tx_data,
  output logic          tx_start,
  output logic          busy,
  output logic [AW:0]   level,
  output logic          dropped
);

  if (LEN < 1 || LEN > (1 << AW)) begin : g_len_check
    $error("uart_line_buffer: LEN must lie in 1..2**AW");
  end

  localparam logic [AW:0] LEN_V = (AW+1)'(LEN);
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  state_t        state;
  state_t        nxt;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] rx_byte;
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ram_addr;
  logic          wr_en;
  logic          line_done;

  // Microorders decoded from the current state.
  assign wr_en = (state == ST_WRITE);

`ifdef LINEBUF_TERM_EN
  assign line_done = ((level + ONE) == LEN_V) || (rx_byte == TERM);
`else
  assign line_done = ((level + ONE) == LEN_V);
`endif

  // Writes go to the fill pointer, everything else reads at the replay pointer.
  // rd_ptr can equal 2**AW after the last byte; its low bits are then unused.
  assign ram_addr = wr_en ? level[AW-1:0] : rd_ptr[AW-1:0];

  genram #(
    .AW       (AW),
    .DW       (DW),
    .INITFILE (INITFILE)
  ) u_store (
    .clk  (clk),
    .we   (wr_en),
    .addr (ram_addr),
    .din  (rx_byte),
    .dout (ram_q)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_RCV:      if (rx_valid) nxt = ST_WRITE;
      ST_WRITE:    nxt = line_done ? ST_READ : ST_RCV;
      ST_READ:     nxt = ST_TX_WAIT;
      ST_TX_WAIT:  if (tx_ready) nxt = ST_TX_START;
      ST_TX_START: nxt = ST_TX_HOLD;
      // Wait for the transmitter to acknowledge by dropping ready before moving on.
      ST_TX_HOLD:  if (!tx_ready) nxt = (rd_ptr < level) ? ST_READ : ST_RCV;
      default:     nxt = ST_RCV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_RCV;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      level    <= '0;
      rd_ptr   <= '0;
      dropped  <= 1'b0;
      tx_data  <= '0;
      rx_byte  <= '0;
    end else begin
      state    <= nxt;
      // Outputs registered from the next state so they line up with the state they describe.
      tx_start <= (nxt == ST_TX_START);
      busy     <= (nxt == ST_READ) || (nxt == ST_TX_WAIT) ||
                  (nxt == ST_TX_START) || (nxt == ST_TX_HOLD);

      if (rx_valid && (state != ST_RCV)) dropped <= 1'b1;
      if (rx_valid && (state == ST_RCV)) rx_byte <= rx_data;
      if (wr_en)                         level   <= level + ONE;
      // RAM output for rd_ptr is valid throughout TX_WAIT; keep loading until the start.
      if (state == ST_TX_WAIT)           tx_data <= ram_q;
      if (state == ST_TX_START)          rd_ptr  <= rd_ptr + ONE;

      if ((state == ST_TX_HOLD) && (nxt == ST_RCV)) begin
        level  <= '0;
        rd_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
module tb_uart_line_buffer;

  localparam int LEN_A = 5;
  localparam int LEN_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0: LEN=5 instance, lane 1: LEN=2**AW=16 boundary instance.
  logic       rstn     [2];
  logic [7:0] rx_data  [2];
  logic       rx_valid [2];
  logic       tx_ready [2];
  logic [7:0] tx_data  [2];
  logic       tx_start [2];
  logic       busy     [2];
  logic [4:0] level    [2];
  logic       dropped  [2];

  uart_line_buffer #(.AW(4), .DW(8), .LEN(LEN_A)) u_dut_a (
    .clk(clk), .rstn(rstn[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
    .busy(busy[0]), .level(level[0]), .dropped(dropped[0])
  );

  uart_line_buffer #(.AW(4), .DW(8), .LEN(LEN_B)) u_dut_b (
    .clk(clk), .rstn(rstn[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
    .busy(busy[1]), .level(level[1]), .dropped(dropped[1])
  );

  int total = 0;
  int bad   = 0;
  bit done0 = 1'b0;
  bit done1 = 1'b0;

  // Reference model: bytes of the line being collected, then a queue of bytes owed to the transmitter.
  logic [7:0] pend     [2][0:15];
  int         pend_n   [2] = '{0, 0};
  logic [7:0] expq     [2][0:1023];
  int         exp_wr   [2] = '{0, 0};
  int         exp_rd   [2] = '{0, 0};
  logic [7:0] obs      [2][0:1023];
  int         obs_n    [2] = '{0, 0};
  logic       exp_drop [2] = '{1'b0, 1'b0};
  logic       prev_st  [2] = '{1'b0, 1'b0};
  logic [7:0] held     [2];

  function automatic int lane_len(input int l);
    return (l == 0) ? LEN_A : LEN_B;
  endfunction

  task automatic chk(input string name, input int l, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s lane%0d: got %0h, want %0h", name, l, act, req);
    end
  endtask

  // A byte joins the line; a full line (or terminator) moves the whole line to the transmit queue.
  task automatic model_accept(input int l, input logic [7:0] b, output bit done);
    pend[l][pend_n[l]] = b;
    pend_n[l]++;
    done = (pend_n[l] == lane_len(l));
`ifdef LINEBUF_TERM_EN
    if (b == 8'h0D) done = 1'b1;
`endif
    if (done) begin
      for (int i = 0; i < pend_n[l]; i++) begin
        expq[l][exp_wr[l]] = pend[l][i];
        exp_wr[l]++;
      end
      pend_n[l] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transmitter: ready falls one cycle after a start and returns a few to twenty cycles later.
  for (genvar g = 0; g < 2; g++) begin : g_txm
    initial begin
      tx_ready[g] = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        if (tx_start[g]) begin
          @(posedge clk);
          #1;
          tx_ready[g] = 1'b0;
          repeat ($urandom_range(3, 20)) @(posedge clk);
          #1;
          tx_ready[g] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      chk("dropped", l, dropped[l], exp_drop[l]);
      if (exp_wr[l] != exp_rd[l]) chk("busy_replay", l, busy[l], 1);
      if (prev_st[l] && rstn[l]) chk("tx_data_hold", l, tx_data[l], held[l]);
      if (tx_start[l]) begin
        chk("start_gap", l, prev_st[l], 0);
        chk("start_pending", l, (exp_wr[l] - exp_rd[l]) > 0, 1);
        if (exp_wr[l] != exp_rd[l]) begin
          chk("tx_data", l, tx_data[l], expq[l][exp_rd[l]]);
          exp_rd[l]++;
        end
        obs[l][obs_n[l]] = tx_data[l];
        obs_n[l]++;
        held[l] = tx_data[l];
      end
      prev_st[l] = tx_start[l];
    end
  end

  task automatic init_lane(input int l);
    rstn[l]     = 1'b0;
    rx_valid[l] = 1'b0;
    rx_data[l]  = 8'h00;
    repeat (3) step();
    chk("rst_tx_start", l, tx_start[l], 0);
    chk("rst_busy",     l, busy[l],     0);
    chk("rst_level",    l, level[l],    0);
    chk("rst_dropped",  l, dropped[l],  0);
    chk("rst_tx_data",  l, tx_data[l],  0);
    rstn[l] = 1'b1;
    step();
  endtask

  // Send one accepted byte; optionally a second strobe in the following (write) cycle.
  task automatic send_byte(input int l, input logic [7:0] b, input bit wr_drop,
                           input logic [7:0] b2, output bit done);
    int lv;
    bit rdy;
    lv          = pend_n[l];
    rdy         = tx_ready[l];
    rx_data[l]  = b;
    rx_valid[l] = 1'b1;
    step();
    if (wr_drop) rx_data[l] = b2;
    rx_valid[l] = wr_drop;
    chk("level_write_cycle", l, level[l], lv);
    step();
    rx_valid[l] = 1'b0;
    if (wr_drop) exp_drop[l] = 1'b1;
    model_accept(l, b, done);
    chk("level_accept", l, level[l], lv + 1);
    if (done) begin
      chk("busy_line_done", l, busy[l], 1);
      if (rdy) begin
        step();
        chk("first_start_early", l, tx_start[l], 0);
        step();
        chk("first_start_latency", l, tx_start[l], 1);
      end
    end
  endtask

  task automatic send_drop(input int l);
    chk("drop_while_busy", l, busy[l], 1);
    rx_data[l]  = 8'($urandom_range(0, 255));
    rx_valid[l] = 1'b1;
    step();
    rx_valid[l] = 1'b0;
    exp_drop[l] = 1'b1;
  endtask

  task automatic send_line(input int l, input bit any_byte, input int drop_at);
    bit         done;
    int         k;
    logic [7:0] b;
    done = 1'b0;
    k    = 0;
    while (!done && k < 16) begin
      b = any_byte ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126));
      send_byte(l, b, (k == drop_at), 8'($urandom_range(0, 255)), done);
      k++;
      if (!done) repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic wait_drain(input int l, input string tag);
    int n;
    n = 0;
    while (((exp_wr[l] != exp_rd[l]) || busy[l]) && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_pending"}, l, exp_wr[l] - exp_rd[l], 0);
    chk({tag, "_busy"},    l, busy[l],  0);
    chk({tag, "_level"},   l, level[l], 0);
  endtask

  task automatic wait_starts(input int l, input int cnt, input string tag);
    int seen;
    int n;
    seen = 0;
    n    = 0;
    while (seen < cnt && n < 2000) begin
      step();
      n++;
      if (tx_start[l]) seen++;
    end
    chk({tag, "_starts"}, l, seen, cnt);
  endtask

  initial begin : drv0
    logic [7:0] hello [5];
    int         base;
    int         n;
    bit         done;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    init_lane(0);

    // HELLO with literal expectations pinning the model.
    base = obs_n[0];
    for (int i = 0; i < 5; i++) begin
      send_byte(0, hello[i], 1'b0, 8'h00, done);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_drain(0, "hello");
    chk("hello_count", 0, obs_n[0] - base, 5);
    for (int i = 0; i < 5; i++) chk("hello_byte", 0, obs[0][base + i], hello[i]);

    // Two lines back to back.
    base = obs_n[0];
    send_line(0, 1'b0, -1);
    wait_drain(0, "line1");
    send_line(0, 1'b0, -1);
    wait_drain(0, "line2");
    chk("b2b_count", 0, obs_n[0] - base, 10);

    // Strobe during the write cycle, then strobes during replay.
    send_line(0, 1'b0, 1);
    wait_drain(0, "wrdrop");
    send_line(0, 1'b0, -1);
    wait_starts(0, 1, "replay_drop");
    send_drop(0);
    repeat (3) step();
    send_drop(0);
    wait_drain(0, "replay_drop");

    // Reset right after the second start of a replay.
    send_line(0, 1'b0, -1);
    wait_starts(0, 2, "mid_reset");
    rstn[0] = 1'b0;
    step();
    exp_wr[0]   = exp_rd[0];
    pend_n[0]   = 0;
    exp_drop[0] = 1'b0;
    chk("reset_tx_start", 0, tx_start[0], 0);
    chk("reset_busy",     0, busy[0],     0);
    chk("reset_level",    0, level[0],    0);
    step();
    rstn[0] = 1'b1;
    n = 0;
    while (!tx_ready[0] && n < 100) begin step(); n++; end
    base = obs_n[0];
    send_line(0, 1'b0, -1);
    wait_drain(0, "after_reset");
    chk("after_reset_count", 0, obs_n[0] - base, 5);

    // Terminator byte.
    base = obs_n[0];
    send_byte(0, 8'h41, 1'b0, 8'h00, done);
    send_byte(0, 8'h0D, 1'b0, 8'h00, done);
`ifdef LINEBUF_TERM_EN
    wait_drain(0, "term");
    chk("term_count", 0, obs_n[0] - base, 2);
    chk("term_byte0", 0, obs[0][base],     8'h41);
    chk("term_byte1", 0, obs[0][base + 1], 8'h0D);
`else
    repeat (10) step();
    chk("noterm_no_start", 0, obs_n[0] - base, 0);
    chk("noterm_level",    0, level[0], 2);
    for (int i = 0; i < 3; i++) send_byte(0, 8'($urandom_range(32, 126)), 1'b0, 8'h00, done);
    wait_drain(0, "noterm");
    chk("noterm_count", 0, obs_n[0] - base, 5);
`endif

    // Random lines with occasional drops.
    for (int r = 0; r < 6; r++) begin
      send_line(0, 1'b1, $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wait_starts(0, 1, "rand_drop");
        send_drop(0);
      end
      wait_drain(0, "rand");
    end
    done0 = 1'b1;
  end

  initial begin : drv1
    int base;
    init_lane(1);
    // Full-depth line: level must reach 16 without wrapping.
    base = obs_n[1];
    send_line(1, 1'b0, -1);
    wait_drain(1, "full16");
    chk("full16_count", 1, obs_n[1] - base, 16);
    send_line(1, 1'b1, -1);
    wait_drain(1, "rand16");
    done1 = 1'b1;
  end

  initial begin : finisher
    int n;
    n = 0;
    while (!(done0 && done1) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    chk("run_complete", 0, done0 && done1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_line_buffer.md
# uart_line_buffer

Parametrised line buffer between a UART receiver and a UART transmitter. It collects received bytes into an internal RAM until a line is complete, then replays the whole line through the transmitter and returns to receiving. Depth, data width and line length are generics, and an optional terminator byte can end a line early. It is the controller stage of the serial echo/store designs and talks to `uart_rx` and `uart_tx` only through their strobe/ready signals.

## Interface
- `AW`, 4: RAM address width; depth is 2^AW words.
- `DW`, 8: data width in bits.
- `LEN`, 5: bytes per line. Legal range is 1..2^AW; values outside it are a synthesis error.
- `TERM`, 8'h0D: terminator byte. Used only when `LINEBUF_TERM_EN` is defined.
- `INITFILE`, "linebufini.list": RAM initial contents.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `rx_data`  in  DW  received byte; valid when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe from the receiver.
- `tx_ready`  in  1  transmitter idle.
- `tx_data`  out  DW  byte to transmit; stable from the `tx_start` cycle until `tx_ready` falls.
- `tx_start`  out  1  one-cycle transmit request.
- `busy`  out  1  high while replaying a line.
- `level`  out  AW+1  bytes stored in the current line.
- `dropped`  out  1  sticky; set when a byte is discarded. Cleared only by reset.

## Operation
- States and transitions:
  - RCV → WRITE when `rx_valid`=1.
  - WRITE → RCV when the line is not yet complete.
  - WRITE → READ when the line is complete: `level` reaches LEN, or (with the macro) the byte equals TERM.
  - READ → TX_WAIT after one cycle.
  - TX_WAIT → TX_START when `tx_ready`=1.
  - TX_START → TX_HOLD after one cycle.
  - TX_HOLD → READ when `tx_ready`=0 and `rd_ptr` < `level`.
  - TX_HOLD → RCV when `tx_ready`=0 and `rd_ptr` = `level`. This exit clears `level` and `rd_ptr` and drops `busy`.
- WRITE: the byte captured in RCV is written at address `level`, then `level` increments.
- READ: the RAM address is set to `rd_ptr`. RAM read is synchronous, so data appears next cycle and is registered into `tx_data` in TX_WAIT.
- TX_START: `tx_start`=1 and `rd_ptr` increments.
- `rx_valid` is ignored in every state except RCV. Each ignored strobe sets `dropped`.
- `busy` is 1 in READ, TX_WAIT, TX_START and TX_HOLD.
- Counters are AW+1 bits and never wrap: `level` ≤ LEN ≤ 2^AW.
- Reset values: state RCV, `tx_start` 0, `busy` 0, `level` 0, `rd_ptr` 0, `dropped` 0, `tx_data` 0.
- Reset during replay aborts the line immediately, with no further `tx_start`.
- RAM contents are never cleared by reset.

## Timing
- Byte accept: `rx_valid` in cycle n → RAM write in n+1 → `level` updated in n+2.
- A strobe arriving in cycle n+1 (the WRITE cycle) is dropped. The receive cadence of a UART makes this unreachable in practice.
- Line complete to first `tx_start`: 3 cycles when `tx_ready` is already 1.
- Per byte after that: TX_HOLD waits for `tx_ready` to fall, then READ + TX_WAIT add 2 cycles before the next `tx_start` once ready returns.
- `tx_start` is never high on two consecutive cycles.

## Configuration
- `LINEBUF_TERM_EN` defined: a received byte equal to TERM is stored, counted and echoed, and ends the line even if `level` < LEN.
- `LINEBUF_TERM_EN` undefined: line end is length only, and TERM is unused.

## Structure
- Package `linebuf_pkg`: state encoding localparams (3 bits) and the default TERM value.
- One sub-module: the existing `genram` (AW, DW, file), instanced as the line store.
- The FSM (registered next state plus combinational microorders `rw`/`cena`/`ccl`-style), `level`/`rd_ptr` counters and `tx_data` register live in the top.
- Receive path: the `level` counter forms the write address.
- Transmit path: `rd_ptr` forms the read address. The address mux is selected by state.

## Test plan
- Length mode, LEN=5: send 'H','E','L','L','O' with `tx_ready` model (ready falls 1 cycle after start, returns 20 cycles later) → exactly 5 `tx_start` pulses carrying 48,45,4C,4C,4F; `busy` 0 afterwards; `level`=0.
- Back-to-back lines: two 5-byte lines → 10 transmits in order; second line does not overwrite the first before its replay finishes.
- Drop: send 2 bytes during replay → `dropped`=1; echoed data unchanged; a strobe in the WRITE cycle also sets `dropped`.
- Terminator (macro on, LEN=5): send 'A',0x0D → 2 transmits (41,0D); `level` returns 0. Macro off → no transmit until 5 bytes.
- Reset mid-replay: assert `rstn`=0 after 2nd `tx_start` → next cycle `tx_start`=0, `busy`=0, `level`=0; subsequent line replays normally.
- Boundary LEN=2^AW=16: 16 bytes stored and replayed; `level` reaches 16 without wrap.
